regfile_scoreboard: RTL and testbench

Parametrised next-generation datapath register file for the single-cycle/pipelined processor. It has two asynchronous read ports, one write port, and an optional hardwired zero register. Writes are on the rising edge with write-to-read bypass, and all storage clears on reset. It adds a per-register pending (scoreboard) bit, set when an instruction issues with that destination and cleared by the writeback, so the control unit can detect RAW hazards and stall.

---
 rtl/regfile_scoreboard.sv | 122 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file, 2 async read ports, 1 write port, optional zero reg.
// Per-register pending bits flag outstanding producers for RAW stalls.
//
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   RA/RB -> BusA/BusB, BusyA/BusyB   read ports and hazard flags
//   RW, BusW, RegWr                   write port (writeback)
//   IssueVld, IssueRd                 destination of an issuing instruction
//   PendCnt                           number of pending registers
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int HAS_ZERO   = 1,
  parameter int ZERO_REG   = 31
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  output logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] BusB,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic [DATA_WIDTH-1:0] BusW,
  input  logic                  RegWr,
  input  logic                  IssueVld,
  input  logic [ADDR_WIDTH-1:0] IssueRd,
  output logic                  BusyA,
  output logic                  BusyB,
  output logic [ADDR_WIDTH:0]   PendCnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic HZ = (HAS_ZERO != 0);
  localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_pend;
  logic [ADDR_WIDTH:0]   r_cnt;

  logic w_zero_a;
  logic w_zero_b;
  logic w_zero_w;
  logic w_zero_i;
  logic w_wr_en;
  logic w_iss_en;
  logic w_set;
  logic w_clr;

  assign w_zero_a = HZ && (RA == ZR);
  assign w_zero_b = HZ && (RB == ZR);
  assign w_zero_w = HZ && (RW == ZR);
  assign w_zero_i = HZ && (IssueRd == ZR);

  assign w_wr_en  = RegWr && !w_zero_w;
  assign w_iss_en = IssueVld && !w_zero_i;

  // Count moves only on real bit transitions. A writeback to the
  // register being re-issued this cycle leaves its bit set.
  assign w_set = w_iss_en && !r_pend[IssueRd];
  assign w_clr = w_wr_en && r_pend[RW] &&
                 !(w_iss_en && (IssueRd == RW));

  always_comb begin
    BusA = r_regs[RA];
    if (w_zero_a)
      BusA = '0;
    else if (w_wr_en && (RW == RA))
      BusA = BusW;
  end

  always_comb begin
    BusB = r_regs[RB];
    if (w_zero_b)
      BusB = '0;
    else if (w_wr_en && (RW == RB))
      BusB = BusW;
  end

  // A writeback landing this cycle resolves the hazard immediately.
  assign BusyA = !w_zero_a && r_pend[RA] &&
                 !(RegWr && (RW == RA));
  assign BusyB = !w_zero_b && r_pend[RB] &&
                 !(RegWr && (RW == RB));

  assign PendCnt = r_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[RW] <= BusW;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_iss_en && (IssueRd == ADDR_WIDTH'(i)))
          r_pend[i] <= 1'b1;
        else if (w_wr_en && (RW == ADDR_WIDTH'(i)))
          r_pend[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_set, w_clr})
        2'b10:   r_cnt <= r_cnt + ONE;
        2'b01:   r_cnt <= r_cnt - ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: table vectors plus hand
// sequences for reset-with-traffic and a build without a zero register.
module tb_regfile_scoreboard;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  RA, RB, RW, IssueRd;
  logic [63:0] BusW;
  logic        RegWr, IssueVld;

  logic [63:0] BusA, BusB, BusA1, BusB1;
  logic        BusyA, BusyB, BusyA1, BusyB1;
  logic [5:0]  PendCnt, PendCnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  regfile_scoreboard #(
    .DATA_WIDTH(64), .ADDR_WIDTH(5), .HAS_ZERO(1), .ZERO_REG(31)
  ) dut (
    .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB),
    .BusA(BusA), .BusB(BusB), .RW(RW), .BusW(BusW),
    .RegWr(RegWr), .IssueVld(IssueVld), .IssueRd(IssueRd),
    .BusyA(BusyA), .BusyB(BusyB), .PendCnt(PendCnt)
  );

  regfile_scoreboard #(
    .DATA_WIDTH(64), .ADDR_WIDTH(5), .HAS_ZERO(0), .ZERO_REG(31)
  ) dut_nz (
    .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB),
    .BusA(BusA1), .BusB(BusB1), .RW(RW), .BusW(BusW),
    .RegWr(RegWr), .IssueVld(IssueVld), .IssueRd(IssueRd),
    .BusyA(BusyA1), .BusyB(BusyB1), .PendCnt(PendCnt1)
  );

  typedef struct {
    logic [4:0]  ra, rb, rw, ird;
    logic [63:0] busw;
    logic        regwr, iv;
    logic [63:0] ea, eb;
    logic        bya, byb;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] ra, rb, rw,
                     input logic [63:0] busw, input logic regwr,
                     input logic iv, input logic [4:0] ird,
                     input logic [63:0] ea, eb,
                     input logic bya, byb, input logic [5:0] cnt);
    vec_t v;
    v.ra = ra; v.rb = rb; v.rw = rw; v.busw = busw;
    v.regwr = regwr; v.iv = iv; v.ird = ird;
    v.ea = ea; v.eb = eb; v.bya = bya; v.byb = byb; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    RegWr = 0; IssueVld = 0; Reset = 0;
    RW = 0; IssueRd = 0; BusW = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    RA = 0; RB = 0;
    idle();
    Reset = 1;
    tick();
    tick();
    Reset = 0;

    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i);
      #1;
      chk($sformatf("rst_busa[%0d]", i), BusA, 64'd0);
      chk($sformatf("rst_busb[%0d]", i), BusB, 64'd0);
      chk($sformatf("rst_busy[%0d]", i), {62'd0, BusyA, BusyB}, 64'd0);
    end
    chk("rst_cnt", 64'(PendCnt), 64'd0);

    //  ra rb rw busw wr iv ird  ea    eb   bya byb cnt
    add(5, 0, 5, DB,    1, 0, 0,  DB,    0,    0, 0, 0);
    add(5, 5, 0, 0,     0, 0, 0,  DB,    DB,   0, 0, 0);
    add(31,5, 31,FF,    1, 0, 0,  0,     DB,   0, 0, 0);
    add(31,31,0, 0,     0, 0, 0,  0,     0,    0, 0, 0);
    add(7, 0, 0, 0,     0, 1, 7,  0,     0,    0, 0, 0);
    add(7, 0, 0, 0,     0, 0, 0,  0,     0,    1, 0, 1);
    add(7, 0, 7, 'h77,  1, 0, 0,  'h77,  0,    0, 0, 1);
    add(7, 7, 0, 0,     0, 0, 0,  'h77,  'h77, 0, 0, 0);
    add(9, 0, 0, 0,     0, 1, 9,  0,     0,    0, 0, 0);
    add(9, 0, 9, 'h99,  1, 1, 9,  'h99,  0,    0, 0, 1);
    add(9, 9, 0, 0,     0, 0, 0,  'h99,  'h99, 1, 1, 1);
    add(9, 0, 0, 0,     0, 1, 9,  'h99,  0,    1, 0, 1);
    add(9, 0, 0, 0,     0, 0, 0,  'h99,  0,    1, 0, 1);
    add(31,0, 0, 0,     0, 1, 31, 0,     0,    0, 0, 1);
    add(31,0, 0, 0,     0, 0, 0,  0,     0,    0, 0, 1);
    add(9, 0, 9, 'h9A,  1, 0, 0,  'h9A,  0,    0, 0, 1);
    add(9, 10,10,'hA0,  1, 0, 0,  'h9A,  'hA0, 0, 0, 0);
    add(10,9, 0, 0,     0, 0, 0,  'hA0,  'h9A, 0, 0, 0);
    add(12,0, 0, 0,     0, 1, 12, 0,     0,    0, 0, 0);
    add(12,0, 12,'hC,   1, 1, 13, 'hC,   0,    0, 0, 1);
    add(12,13,0, 0,     0, 0, 0,  'hC,   0,    0, 1, 1);

    foreach (tbl[k]) begin
      RA = tbl[k].ra; RB = tbl[k].rb; RW = tbl[k].rw;
      BusW = tbl[k].busw; RegWr = tbl[k].regwr;
      IssueVld = tbl[k].iv; IssueRd = tbl[k].ird;
      #2;
      chk($sformatf("v%0d_busa", k), BusA, tbl[k].ea);
      chk($sformatf("v%0d_busb", k), BusB, tbl[k].eb);
      chk($sformatf("v%0d_busya", k), 64'(BusyA), 64'(tbl[k].bya));
      chk($sformatf("v%0d_busyb", k), 64'(BusyB), 64'(tbl[k].byb));
      chk($sformatf("v%0d_cnt", k), 64'(PendCnt), 64'(tbl[k].cnt));
      tick();
    end
    idle();

    // Several producers in flight, then reset with a colliding writeback.
    for (int r = 1; r <= 3; r++) begin
      IssueVld = 1; IssueRd = 5'(r);
      tick();
    end
    idle();
    RA = 2;
    #1;
    chk("pre_rst_busya", 64'(BusyA), 64'd1);
    chk("pre_rst_cnt", 64'(PendCnt), 64'd4);
    Reset = 1; RegWr = 1; RW = 2; BusW = 'h22;
    tick();
    idle();
    RA = 2; RB = 5;
    #1;
    chk("post_rst_busa", BusA, 64'd0);
    chk("post_rst_busb", BusB, 64'd0);
    chk("post_rst_busya", 64'(BusyA), 64'd0);
    chk("post_rst_cnt", 64'(PendCnt), 64'd0);
    RA = 12; RB = 13;
    #1;
    chk("post_rst_busa12", BusA, 64'd0);
    chk("post_rst_busyb13", 64'(BusyB), 64'd0);

    // Late writeback after reset writes data only.
    RegWr = 1; RW = 3; BusW = 'h33;
    tick();
    idle();
    RA = 3;
    #1;
    chk("late_wb_busa", BusA, 64'h33);
    chk("late_wb_busya", 64'(BusyA), 64'd0);
    chk("late_wb_cnt", 64'(PendCnt), 64'd0);

    // Register 31 is ordinary in the build without a zero register.
    RegWr = 1; RW = 31; BusW = 'h1234;
    tick();
    idle();
    RB = 31;
    #1;
    chk("nz_busb31", BusB1, 64'h1234);
    chk("z_busb31", BusB, 64'd0);
    IssueVld = 1; IssueRd = 31;
    tick();
    idle();
    RB = 31;
    #1;
    chk("nz_busyb31", 64'(BusyB1), 64'd1);
    chk("z_busyb31", 64'(BusyB), 64'd0);
    chk("nz_cnt", 64'(PendCnt1), 64'd1);
    chk("z_cnt", 64'(PendCnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
